// File: rtl/alu_ctl_pkg.sv
// alu_ctl_pkg: ALU control encodings (zx nx zy ny f no) and sequencer state codes.
// Revision: 1.0
`default_nettype none

package alu_ctl_pkg;

   localparam logic [5:0] ALU_AND = 6'b000000;
   localparam logic [5:0] ALU_ADD = 6'b000010;
   // Reserved for later multi-cycle controllers.
   localparam logic [5:0] ALU_SUB = 6'b010011;
   localparam logic [5:0] ALU_X   = 6'b001100;
   localparam logic [5:0] ALU_Y   = 6'b110000;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_TEST = 3'd1;
   localparam logic [2:0] ST_ACC  = 3'd2;
   localparam logic [2:0] ST_SHA  = 3'd3;
   localparam logic [2:0] ST_SHM  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: start/operand request and result bus of the multiplier sequencer.
// Revision: 1.0
`default_nettype none

interface alu_mul_seq_if;

   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] OUT;
   logic        zr;
   logic        ng;

   modport master (output start, A, B, input busy, done, OUT, zr, ng);
   modport slave  (input start, A, B, output busy, done, OUT, zr, ng);

endinterface

`default_nettype wire

// File: rtl/alu_mul_seq_alup2.sv
// ALUp2: 16-bit ALU with zero/negate pre-processing on both operands and output negate.
// Revision: 1.0
`default_nettype none

module ALUp2 (
   input  wire logic [15:0] x,
   input  wire logic [15:0] y,
   input  wire logic        zx,
   input  wire logic        nx,
   input  wire logic        zy,
   input  wire logic        ny,
   input  wire logic        f,
   input  wire logic        no,
   output logic      [15:0] out,
   output logic             zr,
   output logic             ng
);

   logic [15:0] w_x0, w_x1, w_y0, w_y1, w_f;

   assign w_x0 = zx ? 16'h0000 : x;
   assign w_x1 = nx ? ~w_x0 : w_x0;
   assign w_y0 = zy ? 16'h0000 : y;
   assign w_y1 = ny ? ~w_y0 : w_y0;
   assign w_f  = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
   assign out  = no ? ~w_f : w_f;
   assign zr   = (out == 16'h0000);
   assign ng   = out[15];

endmodule

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16 -> low-16 shift-and-add multiplier that sequences a single ALUp2.
// Revision: 1.0
`default_nettype none

module alu_mul_seq
   import alu_ctl_pkg::*;
(
   input  wire logic     clk,
   input  wire logic     rst_n,
   alu_mul_seq_if.slave  bus
);

   logic [2:0]  r_state;
   logic [15:0] r_ra, r_rb, r_rp, r_rm;
   logic        r_bit;
   logic [15:0] r_out;
   logic        r_zr, r_ng;

   logic [15:0] w_x, w_y, w_alu_out;
   logic [5:0]  w_ctl;
   logic        w_alu_zr, w_alu_ng;
   logic        w_unused_ng;

   // Operand routing and control word for each micro-step.
   always_comb begin
      w_x   = 16'h0000;
      w_y   = 16'h0000;
      w_ctl = ALU_AND;
      case (r_state)
         ST_TEST: begin w_x = r_rb; w_y = r_rm; w_ctl = ALU_AND; end
         ST_ACC:  begin w_x = r_rp; w_y = r_ra; w_ctl = ALU_ADD; end
         ST_SHA:  begin w_x = r_ra; w_y = r_ra; w_ctl = ALU_ADD; end
         ST_SHM:  begin w_x = r_rm; w_y = r_rm; w_ctl = ALU_ADD; end
         default: begin w_x = 16'h0000; w_y = 16'h0000; w_ctl = ALU_AND; end
      endcase
   end

   ALUp2 u_alu (
      .x   (w_x),
      .y   (w_y),
      .zx  (w_ctl[5]),
      .nx  (w_ctl[4]),
      .zy  (w_ctl[3]),
      .ny  (w_ctl[2]),
      .f   (w_ctl[1]),
      .no  (w_ctl[0]),
      .out (w_alu_out),
      .zr  (w_alu_zr),
      .ng  (w_alu_ng)
   );

   assign w_unused_ng = w_alu_ng;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ra    <= 16'h0000;
         r_rb    <= 16'h0000;
         r_rp    <= 16'h0000;
         r_rm    <= 16'h0000;
         r_bit   <= 1'b0;
         r_out   <= 16'h0000;
         r_zr    <= 1'b0;
         r_ng    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  r_ra    <= bus.A;
                  r_rb    <= bus.B;
                  r_rp    <= 16'h0000;
                  r_rm    <= 16'h0001;
                  r_state <= ST_TEST;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_TEST: begin
               r_bit   <= ~w_alu_zr;
               r_state <= ST_ACC;
            end
            ST_ACC: begin
               if (r_bit) r_rp <= w_alu_out;
               r_state <= ST_SHA;
            end
            ST_SHA: begin
               r_ra    <= w_alu_out;
               r_state <= ST_SHM;
            end
            ST_SHM: begin
               r_rm <= w_alu_out;
               // Mask doubling to zero means bit 15 has just been processed.
               if (w_alu_zr) begin
                  r_out   <= r_rp;
                  r_zr    <= (r_rp == 16'h0000);
                  r_ng    <= r_rp[15];
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_TEST;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (r_state == ST_TEST) || (r_state == ST_ACC) ||
                     (r_state == ST_SHA)  || (r_state == ST_SHM);
   assign bus.done = (r_state == ST_DONE);
   assign bus.OUT  = r_out;
   assign bus.zr   = r_zr;
   assign bus.ng   = r_ng;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed vectors for the sequenced multiplier with hand-computed results.
// Revision: 1.0
`default_nettype none

module tb_alu_mul_seq;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   alu_mul_seq_if bus ();

   alu_mul_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Start in the current cycle (cycle 0), check busy over cycles 1..64 and results at 65.
   // intr: cycle in which a stray start (A=9,B=9) is driven; hold keeps start high throughout.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                         input logic ezr, input logic eng, input int intr, input bit hold,
                         input string tag);
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      tick();
      for (int c = 1; c <= 64; c++) begin
         chk({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
         chk({tag, "_nodone"}, {15'd0, bus.done}, 16'd0);
         if (!hold) bus.start = (c == intr);
         if (c == intr) begin
            bus.A = 16'd9;
            bus.B = 16'd9;
         end
         tick();
      end
      chk({tag, "_done"}, {15'd0, bus.done}, 16'd1);
      chk({tag, "_busy65"}, {15'd0, bus.busy}, 16'd0);
      chk({tag, "_out"}, bus.OUT, exp);
      chk({tag, "_zr"}, {15'd0, bus.zr}, {15'd0, ezr});
      chk({tag, "_ng"}, {15'd0, bus.ng}, {15'd0, eng});
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.A     = 16'h0000;
      bus.B     = 16'h0000;
      tick();
      tick();
      chk("rst_busy", {15'd0, bus.busy}, 16'd0);
      chk("rst_done", {15'd0, bus.done}, 16'd0);
      chk("rst_out",  bus.OUT, 16'h0000);
      chk("rst_zr",   {15'd0, bus.zr}, 16'd0);
      chk("rst_ng",   {15'd0, bus.ng}, 16'd0);
      rst_n = 1'b1;
      tick();

      run_op(16'd3, 16'd5, 16'h000F, 1'b0, 1'b0, 0, 1'b0, "m3x5");
      tick();
      chk("m3x5_idle_done", {15'd0, bus.done}, 16'd0);
      chk("m3x5_idle_busy", {15'd0, bus.busy}, 16'd0);
      chk("m3x5_hold_out",  bus.OUT, 16'h000F);

      run_op(16'hFFFD, 16'd7, 16'hFFEB, 1'b0, 1'b1, 0, 1'b0, "mneg3x7");
      tick();
      run_op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "mffff");
      tick();
      run_op(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 0, 1'b0, "mwrap");
      tick();

      run_op(16'd2, 16'd3, 16'h0006, 1'b0, 1'b0, 10, 1'b0, "mignore");
      tick();

      // Reset asserted in cycle 30 of an operation.
      bus.A     = 16'd5;
      bus.B     = 16'd5;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 30; c++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst31_busy", {15'd0, bus.busy}, 16'd0);
      chk("rst31_done", {15'd0, bus.done}, 16'd0);
      chk("rst31_out",  bus.OUT, 16'h0000);
      tick();
      run_op(16'd4, 16'd4, 16'h0010, 1'b0, 1'b0, 0, 1'b0, "mafterrst");
      tick();

      // Start held high across DONE: back-to-back operations with no IDLE gap.
      run_op(16'd6, 16'd7, 16'h002A, 1'b0, 1'b0, 0, 1'b1, "mb2b_a");
      run_op(16'd6, 16'd7, 16'h002A, 1'b0, 1'b0, 0, 1'b1, "mb2b_b");
      bus.start = 1'b0;
      tick();
      chk("b2b_idle_busy", {15'd0, bus.busy}, 16'd0);
      chk("b2b_idle_out",  bus.OUT, 16'h002A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16-bit multiplier sequencer that time-shares a single `ALUp2` instance. It computes the low 16 bits of A×B by shift-and-add, driving the ALU control bits (zx, nx, zy, ny, f, no) one micro-step per cycle and writing results back into internal registers. It sits beside the CPU datapath as the first block that sequences the ALU, not just instantiates it, and is the template for later multi-cycle ALU controllers.

## Interface
- No parameters; width fixed at 16.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `A` input 16: multiplicand, captured on accepted start.
- `B` input 16: multiplier, captured on accepted start.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when `OUT` becomes valid.
- `OUT` output 16: product low 16 bits; held until the next accepted start.
- `zr` output 1: `OUT == 0`, registered with `OUT`.
- `ng` output 1: `OUT[15]`, registered with `OUT`.

## Operation
- Registers: `ra` (shifted multiplicand), `rb` (multiplier), `rp` (partial product), `rm` (one-hot bit mask), `bit` (1-bit test result).
- On an accepted start: `ra=A`, `rb=B`, `rp=0`, `rm=16'h0001`, next state TEST.
- FSM states: IDLE, TEST, ACC, SHA, SHM, DONE.
- TEST: ALU x=`rb`, y=`rm`, AND (zx nx zy ny f no = 000000); `bit <= ~zr_alu`.
- ACC: ALU x=`rp`, y=`ra`, ADD (000010); `rp` written only if `bit==1`. The cycle is always spent.
- SHA: ALU x=`ra`, y=`ra`, ADD; `ra <=` ALU out, which gives a left shift.
- SHM: ALU x=`rm`, y=`rm`, ADD; `rm <=` ALU out.
  - If ALU zr=1 (mask shifted out after bit 15): go to DONE; load `OUT=rp`, `zr`, `ng`.
  - Otherwise go to TEST.
- Control encodings are applied only through the ALU port bits. No adder or shifter exists outside `ALUp2`.
- Arithmetic is modulo 2^16. Signed and unsigned low-half products are identical, so no sign handling is needed.
- DONE: `done=1`, `busy=0`.
  - With `start=1`, the operation is accepted and the next state is TEST.
  - Otherwise the next state is IDLE.
- `start` while busy (TEST..SHM) is ignored; operand registers are unaffected.
- Reset (any state): state IDLE, all registers 0. Outputs: `busy=0`, `done=0`, `OUT=0`, `zr=0`, `ng=0`.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..64: 16 iterations of TEST/ACC/SHA/SHM, with iteration i occupying cycles 1+4i..4+4i. `busy=1`.
- Cycle 65: DONE; `done=1`, and `OUT`/`zr`/`ng` are valid from this cycle.
- Fixed latency of 65 cycles from start to done, independent of operand values.
- Back-to-back: a start in the DONE cycle begins TEST next cycle, giving a throughput of one result per 65 cycles.
- Reset asserted in cycle n forces IDLE in cycle n+1. A start sampled in cycle n+1 is accepted normally.
- `OUT` does not change between DONE and the next DONE. An intervening reset clears it to 0.

## Structure
- Package `alu_ctl_pkg`:
  - 6-bit control constants `ALU_AND=000000`, `ALU_ADD=000010`. Reserve `ALU_SUB=010011`, `ALU_X=001100`, `ALU_Y=110000` for future sequencers.
  - FSM state enum.
- Sub-module: one instance of the existing `ALUp2`, whose operand muxes are driven from the FSM.
- The FSM and register file live in `alu_mul_seq` itself; no further sub-modules.

## Test plan
- A=3, B=5, start at cycle 0 -> cycle 65: `done=1`, `OUT=0x000F`, `zr=0`, `ng=0`; `busy` high for exactly cycles 1..64.
- A=0xFFFD (-3), B=7 -> `OUT=0xFFEB`, `ng=1`; then A=0xFFFF, B=0xFFFF -> `OUT=0x0001`.
- A=0x0100, B=0x0100 -> `OUT=0x0000`, `zr=1`.
- A=2, B=3; at cycle 10 drive `start` with A=9, B=9 -> ignored; result `0x0006` at cycle 65.
- Start at cycle 0; assert `rst_n=0` in cycle 30 -> cycle 31 `busy=0`, `OUT=0`. Start in cycle 32 with A=4, B=4 -> `done` at cycle 97, `OUT=0x0010`.
- Hold `start=1` with A=6, B=7 across DONE -> `done` at cycles 65 and 130, both with `OUT=0x002A`, and no IDLE cycle between operations.
